// File: rtl/regfile_bypass_pkg.sv
// Shared pipeline constants for the architectural register file and write-back.
package regfile_bypass_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREGS = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] R7_LINK = 3'd7;

endpackage

// File: rtl/regfile_bypass_reg16.sv
// Single register with asynchronous active-low clear and load enable.
module reg16
  import regfile_bypass_pkg::*;
#(
  parameter int unsigned WIDTH = regfile_bypass_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_bypass.sv
// 8x16 register file: two combinational read ports with write-before-read
// bypass, one clocked write port, combinational and sticky error flags.
module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int unsigned WIDTH = regfile_bypass_pkg::WIDTH,
  parameter int unsigned NREGS = regfile_bypass_pkg::NREGS,
  parameter int unsigned SEL_W = regfile_bypass_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] read1RegSel,
  input  logic [SEL_W-1:0] read2RegSel,
  input  logic [SEL_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0] writeData,
  input  logic             writeEn,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  output logic             err,
  output logic             errSticky
);

  logic [NREGS-1:0] wr_en;
  logic [WIDTH-1:0] regs [NREGS];

  // X/Z detection only has meaning in a 4-state simulator; synthesis sees 0.
  always_comb begin
    err = 1'b0;
    if ($isunknown(^writeEn))                              err = 1'b1;
    if ((writeEn === 1'b1) && $isunknown(^writeRegSel))    err = 1'b1;
    if ($isunknown(^read1RegSel) || $isunknown(^read2RegSel)) err = 1'b1;
  end

  always_comb begin
    wr_en = '0;
    if (writeEn && !err) begin
      wr_en[writeRegSel] = 1'b1;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_regs
    reg16 #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wr_en[i]),
      .d     (writeData),
      .q     (regs[i])
    );
  end

  always_comb begin
    read1Data = regs[read1RegSel];
    read2Data = regs[read2RegSel];
    if (writeEn && (writeRegSel == read1RegSel)) read1Data = writeData;
    if (writeEn && (writeRegSel == read2RegSel)) read2Data = writeData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errSticky <= 1'b0;
    end else if (err) begin
      errSticky <= 1'b1;
    end
  end

endmodule
